// File: rtl/food_pkg.sv
// food_pkg: shared constants and types for the food manager
package food_pkg;
   localparam logic [15:0] LFSR_POLY = 16'hB400;
   localparam int XW_DEF = 6;
   localparam int YW_DEF = 5;
   typedef enum logic [1:0] {IDLE, CHECK, SPAWN} state_t;
endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR for food placement
module lfsr16
   import food_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] q
);
   // one Galois step per clock; a nonzero seed keeps the state nonzero forever
   always_ff @(posedge clk or negedge rst)
      if (!rst) q <= SEED;
      else q <= q[0] ? (q >> 1) ^ LFSR_POLY : q >> 1;
endmodule

// File: rtl/food_manager.sv
// food_manager: food slots, head collision, scoring and respawn for the snake game
module food_manager
   import food_pkg::*;
#(
   parameter int GRID_W = 40,
   parameter int GRID_H = 30,
   parameter int XW = XW_DEF,
   parameter int YW = YW_DEF,
   parameter int N_FOOD = 2,
   parameter int TICK_DIV = 250000,
   parameter int SCORE_W = 8,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter int INIT_X = 24,
   parameter int INIT_Y = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [XW-1:0]        headx,
   input  logic [YW-1:0]        heady,
   output logic [N_FOOD*XW-1:0] food_x,
   output logic [N_FOOD*YW-1:0] food_y,
   output logic [N_FOOD-1:0]    food_valid,
   output logic                 add,
   output logic [SCORE_W-1:0]   score,
   output logic                 busy
);
   localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   logic [TW-1:0] cnt;
   logic tick, legal, unused_lf;
   logic [15:0] lf;
   logic [XW-1:0] cx, hx;
   logic [YW-1:0] cy, hy;
   logic [N_FOOD-1:0][XW-1:0] fx;
   logic [N_FOOD-1:0][YW-1:0] fy;
   logic [N_FOOD-1:0] hit, occ, sel;
   state_t state;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst(rst), .q(lf));

   assign unused_lf = ^lf;
   assign cx = lf[XW-1:0];
   assign cy = lf[XW+YW-1:XW];
   assign tick = enable && cnt == TW'(TICK_DIV - 1);
   assign food_x = fx;
   assign food_y = fy;
   assign busy = state != IDLE;

   // per-slot compare of the latched head and of the spawn candidate, plus candidate legality
   always_comb begin
      for (int i = 0; i < N_FOOD; i++) begin
         hit[i] = food_valid[i] && fx[i] == hx && fy[i] == hy;
         occ[i] = food_valid[i] && fx[i] == cx && fy[i] == cy;
      end
      legal = cx >= XW'(1) && cx <= XW'(GRID_W - 2) && cy >= YW'(1) && cy <= YW'(GRID_H - 2)
              && !(cx == hx && cy == hy) && occ == '0;
   end

   // game tick divider, frozen while the game is paused
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt <= '0;
      else if (enable) cnt <= tick ? '0 : cnt + 1'b1;

   // sample head on tick, check all slots at once, then respawn the eaten slot
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         hx <= '0;
         hy <= '0;
         sel <= '0;
         add <= 1'b0;
         score <= '0;
         food_valid <= '1;
         for (int i = 0; i < N_FOOD; i++) begin
            fx[i] <= XW'(INIT_X + 2 * i);
            fy[i] <= YW'(INIT_Y);
         end
      end else begin
         add <= 1'b0;
         if (enable)
            case (state)
               IDLE: if (tick) begin
                  hx <= headx;
                  hy <= heady;
                  state <= CHECK;
               end
               CHECK: if (hit != '0) begin
                  sel <= hit;
                  food_valid <= food_valid & ~hit;
                  add <= 1'b1;
                  score <= score == '1 ? score : score + 1'b1;
                  state <= SPAWN;
               end else state <= IDLE;
               SPAWN: if (legal) begin
                  for (int i = 0; i < N_FOOD; i++)
                     if (sel[i]) begin
                        fx[i] <= cx;
                        fy[i] <= cy;
                     end
                  food_valid <= food_valid | sel;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
      end
endmodule

// File: tb/tb_food_manager.sv
// tb_food_manager: randomized scenario bench for food_manager against a game-level model
module tb_food_manager;
   localparam int TD = 4;
   localparam int SW = 2;
   localparam int N = 2;

   logic clk = 0, rst = 0, enable = 0;
   logic [5:0] headx = 0;
   logic [4:0] heady = 0;
   logic [11:0] food_x;
   logic [9:0] food_y;
   logic [1:0] food_valid;
   logic add, busy;
   logic [SW-1:0] score;

   int pass_cnt = 0, total = 0;
   logic [15:0] ml;
   int ecnt;
   int mfx[N], mfy[N], mscore;
   bit mv[N];

   food_manager #(.TICK_DIV(TD), .SCORE_W(SW)) dut (
      .clk(clk), .rst(rst), .enable(enable), .headx(headx), .heady(heady),
      .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
      .add(add), .score(score), .busy(busy)
   );

   always #5 clk = ~clk;

   // reference random source (x^16+x^14+x^13+x^11+1) and count of enabled cycles since reset
   always @(posedge clk or negedge rst)
      if (!rst) begin
         ml <= 16'hACE1;
         ecnt <= 0;
      end else begin
         ml <= ml[0] ? (ml >> 1) ^ 16'hB400 : ml >> 1;
         if (enable) ecnt <= ecnt + 1;
      end

   function automatic logic [11:0] px();
      return {mfx[1][5:0], mfx[0][5:0]};
   endfunction

   function automatic logic [9:0] py();
      return {mfy[1][4:0], mfy[0][4:0]};
   endfunction

   function automatic logic [1:0] pv();
      return {mv[1], mv[0]};
   endfunction

   function automatic bit legal(logic [15:0] c, int hx, int hy);
      int cx = int'(c[5:0]);
      int cy = int'(c[10:6]);
      if (cx < 1 || cx > 38 || cy < 1 || cy > 28 || (cx == hx && cy == hy)) return 0;
      for (int i = 0; i < N; i++)
         if (mv[i] && mfx[i] == cx && mfy[i] == cy) return 0;
      return 1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         mfx[i] = 24 + 2 * i;
         mfy[i] = 10;
         mv[i] = 1;
      end
      mscore = 0;
   endtask

   // one game tick with the given head; pause holds enable low for the first spawn cycles
   task automatic do_tick(input int hx, input int hy, input int pause, input bit abort);
      int k, n, ox, oy;
      bit acc;
      headx = 6'(hx);
      heady = 5'(hy);
      enable = 1;
      n = 0;
      while (ecnt % TD != TD - 1) begin
         @(negedge clk);
         n++;
         if (n > 4 * TD) begin
            total++;
            $display("FAIL tick_wait: no tick after %0d cycles, required within %0d", n, TD);
            return;
         end
      end
      total++;
      if (busy !== 1'b0) $display("FAIL idle_at_tick: busy=%b required 0", busy);
      else pass_cnt++;
      @(negedge clk);
      total++;
      if (busy !== 1'b1 || add !== 1'b0) $display("FAIL check_cycle: busy=%b add=%b required 1 0", busy, add);
      else pass_cnt++;
      k = -1;
      for (int i = 0; i < N; i++)
         if (mv[i] && mfx[i] == hx && mfy[i] == hy) k = i;
      if (k >= 0) begin
         mv[k] = 0;
         mscore = mscore < 3 ? mscore + 1 : 3;
      end
      @(negedge clk);
      total++;
      if (add !== (k >= 0) || busy !== (k >= 0) || score !== SW'(mscore) || food_valid !== pv())
         $display("FAIL after_check(%0d,%0d): add=%b busy=%b score=%0d valid=%b required %b %b %0d %b",
                  hx, hy, add, busy, score, food_valid, k >= 0, k >= 0, mscore, pv());
      else pass_cnt++;
      if (k < 0) return;
      if (abort) begin
         rst = 0;
         #1;
         model_reset();
         total++;
         if (food_x !== px() || food_y !== py() || food_valid !== 2'b11 || add !== 1'b0 || score !== '0 || busy !== 1'b0)
            $display("FAIL reset_mid_spawn: x=%h y=%h valid=%b add=%b score=%0d busy=%b required x=%h y=%h 11 0 0 0",
                     food_x, food_y, food_valid, add, score, busy, px(), py());
         else pass_cnt++;
         @(negedge clk);
         rst = 1;
         @(negedge clk);
         total++;
         if (food_x !== px() || food_y !== py() || food_valid !== 2'b11 || add !== 1'b0 || score !== '0 || busy !== 1'b0)
            $display("FAIL reset_release: x=%h y=%h valid=%b add=%b score=%0d busy=%b required x=%h y=%h 11 0 0 0",
                     food_x, food_y, food_valid, add, score, busy, px(), py());
         else pass_cnt++;
         return;
      end
      acc = 0;
      for (int j = 0; j < 1000 && !acc; j++) begin
         enable = j >= pause;
         if (enable && legal(ml, hx, hy)) begin
            mfx[k] = int'(ml[5:0]);
            mfy[k] = int'(ml[10:6]);
            mv[k] = 1;
            acc = 1;
         end
         @(negedge clk);
         total++;
         if (add !== 1'b0 || busy !== !acc || food_valid !== pv() || food_x !== px() || food_y !== py() || score !== SW'(mscore))
            $display("FAIL spawn_cycle%0d: add=%b busy=%b valid=%b x=%h y=%h score=%0d required 0 %b %b %h %h %0d",
                     j, add, busy, food_valid, food_x, food_y, score, !acc, pv(), px(), py(), mscore);
         else pass_cnt++;
      end
      enable = 1;
      if (!acc) begin
         total++;
         $display("FAIL spawn_timeout: slot %0d never respawned", k);
      end
      ox = int'(k == 0 ? food_x[5:0] : food_x[11:6]);
      oy = int'(k == 0 ? food_y[4:0] : food_y[9:5]);
      n = k == 0 ? 1 : 0;
      total++;
      if (ox < 1 || ox > 38 || oy < 1 || oy > 28 || (ox == hx && oy == hy) || (ox == mfx[n] && oy == mfy[n]))
         $display("FAIL spawn_legal: slot %0d at (%0d,%0d) required interior, not head (%0d,%0d), not other slot",
                  k, ox, oy, hx, hy);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      model_reset();
      repeat (3) @(negedge clk);
      total++;
      if (food_x !== 12'h69_8 || food_y !== 10'h14A || food_valid !== 2'b11 || add !== 1'b0 || score !== '0 || busy !== 1'b0)
         $display("FAIL reset_hold: x=%h y=%h valid=%b add=%b score=%0d busy=%b required 698 14a 11 0 0 0",
                  food_x, food_y, food_valid, add, score, busy);
      else pass_cnt++;
      rst = 1;
      @(negedge clk);
      total++;
      if (food_x !== px() || food_y !== py() || food_valid !== 2'b11 || add !== 1'b0 || score !== '0 || busy !== 1'b0)
         $display("FAIL reset_release: x=%h y=%h valid=%b add=%b score=%0d busy=%b required %h %h 11 0 0 0",
                  food_x, food_y, food_valid, add, score, busy, px(), py());
      else pass_cnt++;
   endtask

   task automatic test_eat();
      do_tick(24, 10, 0, 0);
      total++;
      if (score !== 2'd1) $display("FAIL eat_first_score: score=%0d required 1", score);
      else pass_cnt++;
      for (int i = 0; i < 6; i++) begin
         int k = int'($urandom_range(0, 1));
         do_tick(mfx[k], mfy[k], int'($urandom_range(0, 3)), 0);
      end
   endtask

   task automatic test_miss();
      logic [SW-1:0] s0 = score;
      do_tick(0, 10, 0, 0);
      do_tick(39, 5, 0, 0);
      do_tick(5, 5, 0, 0);
      for (int i = 0; i < 10; i++) begin
         int x, y;
         do begin
            x = int'($urandom_range(0, 39));
            y = int'($urandom_range(0, 29));
         end while ((x == mfx[0] && y == mfy[0]) || (x == mfx[1] && y == mfy[1]));
         do_tick(x, y, 0, 0);
      end
      total++;
      if (score !== s0) $display("FAIL miss_score: score=%0d required %0d", score, s0);
      else pass_cnt++;
   endtask

   task automatic test_score_sat();
      int exp_s[5] = '{1, 2, 3, 3, 3};
      @(negedge clk);
      rst = 0;
      #1;
      model_reset();
      @(negedge clk);
      rst = 1;
      for (int i = 0; i < 5; i++) begin
         int k = int'($urandom_range(0, 1));
         do_tick(mfx[k], mfy[k], 0, 0);
         total++;
         if (score !== SW'(exp_s[i])) $display("FAIL score_sat%0d: score=%0d required %0d", i, score, exp_s[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++)
         do_tick(mfx[i % 2], mfy[i % 2], 0, 0);
   endtask

   task automatic test_pause_spawn();
      do_tick(mfx[1], mfy[1], 6, 0);
      do_tick(mfx[0], mfy[0], 3, 0);
   endtask

   task automatic test_reset_spawn();
      do_tick(mfx[0], mfy[0], 0, 1);
      do_tick(mfx[1], mfy[1], 0, 0);
      total++;
      if (score !== 2'd1) $display("FAIL post_reset_score: score=%0d required 1", score);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_eat();
      test_miss();
      test_score_sat();
      test_back_to_back();
      test_pause_spawn();
      test_reset_spawn();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule

// File: doc/food_manager.md
Name: food_manager

Overview:
Parametrised successor to the snake game's food/eating logic. Manages N_FOOD food items on a GRID_W x GRID_H board and checks the snake head against every item on each game tick. On a hit it pulses add and increments a saturating score. It then respawns the eaten item at an LFSR-chosen legal cell. Sits between the snake movement controller (head coordinates) and the VGA renderer (food coordinates, valid flags).

Parameters:
GRID_W, 40, board width in cells; column 0 and column GRID_W-1 are walls
GRID_H, 30, board height in cells; row 0 and row GRID_H-1 are walls
XW, 6, x coordinate width; requires 2^XW >= GRID_W
YW, 5, y coordinate width; requires 2^YW >= GRID_H
N_FOOD, 2, number of simultaneous food items, 1..4
TICK_DIV, 250000, clk cycles per game tick
SCORE_W, 8, score width
LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero
INIT_X, 24, reset x of slot 0; slot i resets to INIT_X+2*i; all must be legal cells
INIT_Y, 10, reset y of all slots

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
enable  in  1  game running; 0 freezes the tick counter and the FSM
headx  in  XW  snake head x
heady  in  YW  snake head y
food_x  out  N_FOOD*XW  packed food x coordinates; slot i at [i*XW +: XW]
food_y  out  N_FOOD*YW  packed food y coordinates
food_valid  out  N_FOOD  slot holds displayable food
add  out  1  one-cycle pulse: snake grows at its next step
score  out  SCORE_W  food eaten count, saturating
busy  out  1  FSM is not in IDLE

Behaviour:
- Reset values:
  - food_x/food_y = init positions; food_valid = all ones
  - add = 0, score = 0, busy = 0
  - tick counter = 0, LFSR = LFSR_SEED, FSM = IDLE
- Tick counter:
  - Counts 0..TICK_DIV-1 while enable=1.
  - Raises an internal one-cycle tick at TICK_DIV-1, then wraps to 0.
  - Holds its value while enable=0.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every clk regardless of enable; never reaches zero.
- FSM states IDLE, CHECK, SPAWN.
  - IDLE: on tick, register headx/heady, go to CHECK. busy=0.
  - CHECK (1 cycle): compare the registered head against every valid slot in parallel.
    - Hit on slot k: clear food_valid[k], set add=1 for exactly this cycle's registered output (visible the cycle after CHECK), increment score (saturates at all-ones), go to SPAWN.
    - No hit: go to IDLE.
    - Slots are kept distinct, so at most one hit can occur.
  - SPAWN: each cycle, take candidate cx = lfsr[XW-1:0], cy = lfsr[XW+YW-1:XW].
    - Accept if 1<=cx<=GRID_W-2, 1<=cy<=GRID_H-2, the candidate does not equal the registered head, and it does not equal any currently valid slot.
    - On accept: write the slot, set food_valid[k]=1, go to IDLE.
    - On reject: stay in SPAWN; retry with the next LFSR value.
    - There is no retry limit.
- Ticks arriving while busy=1 are dropped. The tick counter keeps running.
- add latency: 2 clk after the tick cycle (tick -> CHECK -> add high). Width is exactly 1 cycle.
- enable=0 mid-SPAWN: the FSM holds its state; the LFSR still advances; spawning resumes when enable returns to 1.
- rst asserted mid-operation: every register returns to its reset value immediately; no partial write survives.
- A head on a wall cell, or a head matching no slot: never a hit; no side effects.
- Width rules: all comparisons are unsigned at full XW/YW width; no modulo fold-back of out-of-range candidates.

Decomposition:
- Package food_pkg:
  - LFSR polynomial constant
  - FSM state typedef (IDLE/CHECK/SPAWN)
  - coordinate width defaults
- Sub-module lfsr16: seed parameter, enable-free, outputs the 16-bit state.
- Candidate legality check and slot compare stay inline as combinational logic.

Test Plan:
- Reset with defaults -> food (24,10) and (26,10), food_valid=2'b11, score=0, add=0, busy=0.
- TICK_DIV=4, head (24,10) held -> add high for 1 cycle, 2 clk after the tick; score=1; food_valid[0] low until respawn; the new slot 0 satisfies 1<=x<=38, 1<=y<=28, differs from (24,10) and from (26,10).
- Head (5,5), no food there, across 10 ticks -> add never asserts; score stays 0; busy high for exactly 1 cycle per tick.
- Force SPAWN; pulse extra ticks while busy=1 -> no second CHECK; score increments once only.
- SCORE_W=2, eat 5 times -> score sequence 1,2,3,3,3; add pulses all 5 times.
- Assert rst during SPAWN -> next cycle all outputs equal reset values, FSM IDLE; enable=0 during SPAWN -> no slot write until enable=1.
